apb_master: RTL and testbench
=============================

# apb_master

APB requester (master) for the 8-bit-address / 16-bit-data APB bus served by the existing APB slave. It takes single read or write commands from a local valid/ready interface, runs the APB SETUP → ACCESS sequence, and honours slave wait states through `p_ready`. It returns one response per command, with a bounded wait timeout so a hung slave cannot stall the requester. It sits between on-chip control logic and the APB slave memory, and also serves as the bus driver for slave-level benches.

## Interface
Parameters:
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 16: APB data width.
- `TIMEOUT`, 16: maximum ACCESS cycles before abort; must be ≥ 2.

Ports:
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command; registered.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: command address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: read data; 0 for writes and for timeouts.
- `rsp_timeout` out 1: qualifies `rsp_valid`; 1 = transfer aborted.
- `p_sel` out 1: APB select.
- `p_en` out 1: APB enable.
- `addr` out ADDR_W: APB address.
- `wr` out 1: APB write (1) / read (0).
- `w_data` out DATA_W: APB write data.
- `r_data` in DATA_W: APB read data from the slave.
- `p_ready` in 1: slave ready; sampled only in ACCESS.

## Operation
- Reset (`rst` = 0), asynchronous: state IDLE. The following outputs are 0: `cmd_ready`, `rsp_valid`, `rsp_rdata`, `rsp_timeout`, `p_sel`, `p_en`, `addr`, `wr`, `w_data`. The wait counter is 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready` is 1 from the first edge after reset release.
  - On an edge with `cmd_valid & cmd_ready`: latch `cmd_addr`/`cmd_wr`/`cmd_wdata` into `addr`/`wr`/`w_data`, clear `cmd_ready`, go to SETUP.
- SETUP: `p_sel` = 1, `p_en` = 0; after one cycle, unconditionally go to ACCESS and clear the wait counter.
- ACCESS: `p_sel` = 1, `p_en` = 1.
  - Edge with `p_ready` = 1: transfer completes.
    - Next state IDLE; `p_sel` = `p_en` = 0; `cmd_ready` = 1.
    - `rsp_valid` = 1 and `rsp_timeout` = 0.
    - `rsp_rdata` = `r_data` sampled at that edge if `wr` = 0, else 0.
  - Edge with `p_ready` = 0 and wait count < `TIMEOUT`-1: increment the counter and stay in ACCESS.
  - Edge with `p_ready` = 0 and wait count = `TIMEOUT`-1: abort.
    - Next state IDLE; `p_sel` = `p_en` = 0; `cmd_ready` = 1.
    - `rsp_valid` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
- `addr`/`wr`/`w_data` are stable from SETUP until completion, then hold their last value until the next accept.
- `rsp_valid` is high for exactly one cycle; `rsp_rdata`/`rsp_timeout` hold until the next response.
- `cmd_valid` while `cmd_ready` = 0 is ignored. There is no queueing; the requester must hold the command.
- `p_ready` and `r_data` are ignored outside ACCESS.
- Wait-counter width is clog2(`TIMEOUT`). The counter never wraps: abort occurs first.

## Timing
- Accept at edge E0. SETUP is the cycle after E0; ACCESS starts after E1.
- Zero-wait transfer: `p_ready` = 1 sampled at E2.
  - `rsp_valid` and `cmd_ready` are high in the cycle after E2.
  - The earliest next accept is E3, so back-to-back throughput is one transfer per 3 cycles.
- N wait states: completion at E(2+N), `rsp_valid` after that edge.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles. With the default of 16, the abort edge is E17.
- Reset asserted mid-transfer: `p_sel`/`p_en` drop immediately (asynchronously) and no `rsp_valid` is generated for the lost command.
- A new accept may occur in the same cycle that `rsp_valid` is high.

## Test plan
- Write `addr`=0xEF, `w_data`=0xABCD, `p_ready` = 1 immediately:
  - SETUP 1 cycle, then ACCESS 1 cycle.
  - `rsp_valid` one cycle with `rsp_timeout` = 0 and `rsp_rdata` = 0.
  - The slave's memory location 0xEF reads back 0xABCD.
- Read 0xEF with `p_ready` held low for 3 ACCESS cycles and `r_data` = 0xABCD:
  - `addr`/`wr`/`w_data` stable throughout.
  - `rsp_valid` at E5 + 1 cycle with `rsp_rdata` = 0xABCD.
- Read with `p_ready` never asserted, `TIMEOUT` = 16:
  - `p_en` high for exactly 16 cycles.
  - `rsp_valid` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - `cmd_ready` returns to 1.
- `cmd_valid` held high for 4 back-to-back writes to 0x00..0x03, zero wait:
  - Accepts exactly every 3 cycles.
  - No command is dropped or duplicated (4 `rsp_valid` pulses).
  - `cmd_valid` during busy is ignored.
- Reset pulse during ACCESS of a write:
  - All outputs go to 0 asynchronously and no `rsp_valid` is generated.
  - `cmd_ready` = 1 one edge after release.
  - A following read of 0xEF completes normally.

Source files
------------

// File: rtl/apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Purpose  : APB requester. Accepts single read/write commands on a local
//             valid/ready interface, runs the APB SETUP -> ACCESS sequence,
//             honours slave wait states and aborts after TIMEOUT ACCESS
//             cycles so a hung slave cannot stall the requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rst          in   asynchronous active-low reset
//    cmd_valid    in   command request
//    cmd_ready    out  command can be accepted (registered)
//    cmd_wr       in   1 = write, 0 = read
//    cmd_addr     in   command address
//    cmd_wdata    in   command write data
//    rsp_valid    out  one-cycle response pulse
//    rsp_rdata    out  read data (0 for writes and timeouts)
//    rsp_timeout  out  response was an abort
//    p_sel        out  APB select
//    p_en         out  APB enable
//    addr         out  APB address
//    wr           out  APB write
//    w_data       out  APB write data
//    r_data       in   APB read data
//    p_ready      in   APB ready (only looked at in ACCESS)
// ============================================================================
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              p_sel,
  output logic              p_en,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              p_ready
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits, so the counter cannot wrap
  // before the abort condition is reached.
  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state,        state_nx;
  logic [CNT_W-1:0]    wait_cnt,     wait_cnt_nx;
  logic                cmd_ready_nx;
  logic                rsp_valid_nx;
  logic [DATA_W-1:0]   rsp_rdata_nx;
  logic                rsp_timeout_nx;
  logic                p_sel_nx,     p_en_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic                wr_nx;
  logic [DATA_W-1:0]   w_data_nx;

  // All outputs are registered; the reset drops the bus asynchronously so a
  // transfer in flight is abandoned without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      p_sel       <= 1'b0;
      p_en        <= 1'b0;
      addr        <= '0;
      wr          <= 1'b0;
      w_data      <= '0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      cmd_ready   <= cmd_ready_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_timeout <= rsp_timeout_nx;
      p_sel       <= p_sel_nx;
      p_en        <= p_en_nx;
      addr        <= addr_nx;
      wr          <= wr_nx;
      w_data      <= w_data_nx;
    end
  end

  always_comb begin
    // Hold everything by default; the response strobe is a single pulse.
    state_nx       = state;
    wait_cnt_nx    = wait_cnt;
    cmd_ready_nx   = cmd_ready;
    rsp_valid_nx   = 1'b0;
    rsp_rdata_nx   = rsp_rdata;
    rsp_timeout_nx = rsp_timeout;
    p_sel_nx       = p_sel;
    p_en_nx        = p_en;
    addr_nx        = addr;
    wr_nx          = wr;
    w_data_nx      = w_data;

    case (state)
      ST_IDLE: begin
        // cmd_ready is registered low out of reset, so the first edge after
        // release only raises it; accepts start one edge later.
        cmd_ready_nx = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_nx     = ST_SETUP;
          cmd_ready_nx = 1'b0;
          addr_nx      = cmd_addr;
          wr_nx        = cmd_wr;
          w_data_nx    = cmd_wdata;
          p_sel_nx     = 1'b1;
          p_en_nx      = 1'b0;
        end
      end

      ST_SETUP: begin
        state_nx    = ST_ACCESS;
        p_en_nx     = 1'b1;
        wait_cnt_nx = '0;
      end

      ST_ACCESS: begin
        if (p_ready) begin
          state_nx       = ST_IDLE;
          p_sel_nx       = 1'b0;
          p_en_nx        = 1'b0;
          cmd_ready_nx   = 1'b1;
          rsp_valid_nx   = 1'b1;
          rsp_timeout_nx = 1'b0;
          rsp_rdata_nx   = wr ? '0 : r_data;
        end else if (wait_cnt == CNT_MAX) begin
          state_nx       = ST_IDLE;
          p_sel_nx       = 1'b0;
          p_en_nx        = 1'b0;
          cmd_ready_nx   = 1'b1;
          rsp_valid_nx   = 1'b1;
          rsp_timeout_nx = 1'b1;
          rsp_rdata_nx   = '0;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_ONE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        p_sel_nx = 1'b0;
        p_en_nx  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Purpose  : Self-checking bench for apb_master. A behavioural APB slave
//             with configurable wait states serves the bus; expectations
//             come from a transaction-level model (latency formula and a
//             reference memory image).
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              p_sel;
  logic              p_en;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              p_ready;

  int total = 0;
  int bad   = 0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .p_sel(p_sel), .p_en(p_en), .addr(addr), .wr(wr), .w_data(w_data),
    .r_data(r_data), .p_ready(p_ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural APB slave ----------------
  logic [DATA_W-1:0] slv_mem [256];
  logic              mem_init_done = 1'b0;
  int                waits_cfg = 0;   // <0 : never ready
  int                acc_cnt = 0;
  logic              noise_rdy = 1'b0;
  logic [DATA_W-1:0] noise_data = '0;

  always @(posedge clk) begin
    noise_rdy  <= 1'($urandom);
    noise_data <= 16'($urandom);
    if (p_sel && p_en && !p_ready) acc_cnt <= acc_cnt + 1;
    else                           acc_cnt <= 0;
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (p_sel && p_en && p_ready && wr) begin
      slv_mem[addr] <= w_data;
    end
  end

  // Outside ACCESS the slave drives garbage on p_ready/r_data.
  always_comb begin
    if (p_sel && p_en) p_ready = (waits_cfg >= 0) && (acc_cnt >= waits_cfg);
    else               p_ready = noise_rdy;
    if (p_sel && p_en && p_ready && !wr) r_data = slv_mem[addr];
    else                                 r_data = noise_data;
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [256];

  function automatic logic completes(input int nw);
    return (nw >= 0) && (nw < TIMEOUT);
  endfunction

  // cycles from accept edge to the cycle where rsp_valid is seen
  function automatic int model_latency(input int nw);
    return completes(nw) ? 3 + nw : 2 + TIMEOUT;
  endfunction

  function automatic int model_access_cycles(input int nw);
    return completes(nw) ? nw + 1 : TIMEOUT;
  endfunction

  // Drive one command and observe the transfer; no checking here.
  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [15:0] d,
                         input int nw, output int lat, output int pen_cyc,
                         output int setup_cyc, output logic [15:0] rd,
                         output logic to, output logic stable,
                         output logic rdy_at_rsp, output logic acc_ok);
    lat = -1; pen_cyc = 0; setup_cyc = 0; rd = '0; to = 1'b0;
    stable = 1'b1; rdy_at_rsp = 1'b0; acc_ok = 1'b0;
    waits_cfg = nw;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) begin acc_ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc_ok) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    // scramble the command bus to prove the request was latched
    cmd_valid = 1'b0; cmd_wr = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    for (int k = 1; k <= 64; k++) begin
      if (addr !== a || wr !== w || w_data !== d) stable = 1'b0;
      if (p_sel && !p_en) setup_cyc++;
      if (p_sel && p_en) pen_cyc++;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; to = rsp_timeout; rdy_at_rsp = cmd_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [57:0] outs;
    #2 rst = 1'b0;          // asserted before any clock edge
    #1;
    outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, p_sel, p_en, addr, wr, w_data};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_async outs=%h want 0", outs); end
    repeat (3) @(negedge clk);
    outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, p_sel, p_en, addr, wr, w_data};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_held outs=%h want 0", outs); end
    rst = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_release_ready got=%b want 0", cmd_ready); end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_first_edge_ready got=%b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int lat, pen, stp; logic [15:0] rd; logic to, st, rdy, ok;
    run_cmd(1'b1, 8'hEF, 16'hABCD, 0, lat, pen, stp, rd, to, st, rdy, ok);
    ref_mem[8'hEF] = 16'hABCD;
    total++;
    if (!ok || lat !== model_latency(0)) begin bad++; $display("FAIL write_latency got=%0d want %0d", lat, model_latency(0)); end
    total++;
    if (stp !== 1 || pen !== model_access_cycles(0)) begin bad++; $display("FAIL write_phases setup=%0d access=%0d want 1/1", stp, pen); end
    total++;
    if (to !== 1'b0 || rd !== 16'h0) begin bad++; $display("FAIL write_rsp to=%b rdata=%h want 0/0000", to, rd); end
    total++;
    if (!st) begin bad++; $display("FAIL write_bus_stable got=0 want 1"); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL write_rsp_pulse_width rsp_valid=%b want 0", rsp_valid); end
    total++;
    if (slv_mem[8'hEF] !== ref_mem[8'hEF]) begin bad++; $display("FAIL write_memory got=%h want %h", slv_mem[8'hEF], ref_mem[8'hEF]); end
  endtask

  task automatic test_read_wait();
    int lat, pen, stp; logic [15:0] rd; logic to, st, rdy, ok;
    run_cmd(1'b0, 8'hEF, 16'h5A5A, 3, lat, pen, stp, rd, to, st, rdy, ok);
    total++;
    if (!ok || lat !== model_latency(3)) begin bad++; $display("FAIL read_wait_latency got=%0d want %0d", lat, model_latency(3)); end
    total++;
    if (pen !== model_access_cycles(3)) begin bad++; $display("FAIL read_wait_access got=%0d want %0d", pen, model_access_cycles(3)); end
    total++;
    if (rd !== ref_mem[8'hEF] || to !== 1'b0) begin bad++; $display("FAIL read_wait_data rdata=%h to=%b want %h/0", rd, to, ref_mem[8'hEF]); end
    total++;
    if (!st) begin bad++; $display("FAIL read_wait_bus_stable got=0 want 1"); end
  endtask

  task automatic test_timeout();
    int lat, pen, stp; logic [15:0] rd; logic to, st, rdy, ok;
    run_cmd(1'b0, 8'hEF, 16'h0000, -1, lat, pen, stp, rd, to, st, rdy, ok);
    total++;
    if (!ok || pen !== TIMEOUT) begin bad++; $display("FAIL timeout_access_cycles got=%0d want %0d", pen, TIMEOUT); end
    total++;
    if (lat !== model_latency(-1)) begin bad++; $display("FAIL timeout_latency got=%0d want %0d", lat, model_latency(-1)); end
    total++;
    if (to !== 1'b1 || rd !== 16'h0) begin bad++; $display("FAIL timeout_rsp to=%b rdata=%h want 1/0000", to, rd); end
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL timeout_ready got=%b want 1", rdy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [4];
    int acc_cyc [4];
    int n_acc = 0, rsp_cnt = 0, setup_cnt = 0, cyc = 0, idx = 0;
    logic acc;
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    waits_cfg = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd0; cmd_wdata = d[0];
    while (rsp_cnt < 4 && cyc < 60) begin
      if (rsp_valid) rsp_cnt++;
      if (p_sel && !p_en) setup_cnt++;
      acc = cmd_valid && cmd_ready;
      if (acc && n_acc < 4) begin acc_cyc[n_acc] = cyc; n_acc++; end
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin cmd_addr = 8'(idx); cmd_wdata = d[idx]; end
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[i] = d[i];
    total++;
    if (n_acc !== 4 || rsp_cnt !== 4 || setup_cnt !== 4) begin
      bad++; $display("FAIL b2b_counts accepts=%0d rsps=%0d setups=%0d want 4/4/4", n_acc, rsp_cnt, setup_cnt);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (i < n_acc && acc_cyc[i] - acc_cyc[i-1] !== 3) begin
        bad++; $display("FAIL b2b_interval%0d got=%0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
      end else if (i >= n_acc) begin
        bad++; $display("FAIL b2b_interval%0d got=missing want 3", i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (slv_mem[i] !== ref_mem[i]) begin bad++; $display("FAIL b2b_mem%0d got=%h want %h", i, slv_mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [57:0] outs;
    logic seen = 1'b0, ok = 1'b0, rdy1;
    int lat, pen, stp; logic [15:0] rd; logic to, st, rdy, aok;
    waits_cfg = 8;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h55; cmd_wdata = 16'h1234;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (p_en) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_reach_access got=0 want 1"); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, p_sel, p_en, addr, wr, w_data};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL rstmid_async outs=%h want 0", outs); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rdy1 = cmd_ready;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (rdy1 !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want 1", rdy1); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%b want 0", seen); end
    total++;
    if (slv_mem[8'h55] !== ref_mem[8'h55]) begin bad++; $display("FAIL rstmid_no_write got=%h want %h", slv_mem[8'h55], ref_mem[8'h55]); end
    run_cmd(1'b0, 8'hEF, 16'h0000, 1, lat, pen, stp, rd, to, st, rdy, aok);
    total++;
    if (!aok || lat !== model_latency(1) || to !== 1'b0 || rd !== ref_mem[8'hEF]) begin
      bad++; $display("FAIL rstmid_followup lat=%0d to=%b rdata=%h want %0d/0/%h", lat, to, rd, model_latency(1), ref_mem[8'hEF]);
    end
  endtask

  task automatic test_random();
    logic [7:0] wq [$];
    int lat, pen, stp, nw, r; logic [15:0] rd, d, erd; logic to, st, rdy, ok, w, eto;
    logic [7:0] a;
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom);
      a = 8'($urandom);
      if (!w && wq.size() > 0 && $urandom_range(0, 3) != 0) a = wq[$urandom_range(0, wq.size() - 1)];
      d = 16'($urandom);
      r = $urandom_range(0, 9);
      nw = (r == 9) ? 40 : r % 5;
      eto = !completes(nw);
      erd = (w || eto) ? 16'h0 : ref_mem[a];
      run_cmd(w, a, d, nw, lat, pen, stp, rd, to, st, rdy, ok);
      if (w && !eto) begin ref_mem[a] = d; wq.push_back(a); end
      total++;
      if (!ok || lat !== model_latency(nw) || pen !== model_access_cycles(nw)) begin
        bad++; $display("FAIL rand%0d_timing lat=%0d access=%0d want %0d/%0d", i, lat, pen, model_latency(nw), model_access_cycles(nw));
      end
      total++;
      if (rd !== erd || to !== eto) begin
        bad++; $display("FAIL rand%0d_rsp rdata=%h to=%b want %h/%b", i, rd, to, erd, eto);
      end
      total++;
      if (!st || !rdy) begin bad++; $display("FAIL rand%0d_bus stable=%b ready=%b want 1/1", i, st, rdy); end
    end
    @(negedge clk);
    for (int i = 0; i < wq.size(); i++) begin
      total++;
      if (slv_mem[wq[i]] !== ref_mem[wq[i]]) begin
        bad++; $display("FAIL rand_mem addr=%h got=%h want %h", wq[i], slv_mem[wq[i]], ref_mem[wq[i]]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
